// File: rtl/fp_special_pkg.sv
// Shared field helpers, special-value constants and case encoding for the
// FP multiply special-case front end. Widths travel as arguments so one
// package serves fp16/bf16/fp32/fp64 instances.
package fp_special_pkg;

  localparam int FP_MAX_W = 64;

  typedef struct packed {
    logic                sign;
    logic [FP_MAX_W-1:0] exp;
    logic [FP_MAX_W-1:0] mant;
  } fp_fields_t;

  typedef enum logic [2:0] {
    CASE_NAN_A,
    CASE_NAN_B,
    CASE_INF_ZERO,
    CASE_INF,
    CASE_ZERO,
    CASE_NORMAL
  } fp_case_e;

  // n low ones; n >= 64 saturates to all ones
  function automatic logic [FP_MAX_W-1:0] fp_mask(input int n);
    return (n >= FP_MAX_W) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  // Split an operand into sign / biased exponent / mantissa
  function automatic fp_fields_t fp_unpack(input logic [FP_MAX_W-1:0] op,
                                           input int fp_width, input int exp_msb,
                                           input int exp_lsb);
    fp_fields_t f;
    f.sign = op[fp_width-1];
    f.exp  = (op >> exp_lsb) & fp_mask(exp_msb - exp_lsb + 1);
    f.mant = op & fp_mask(exp_lsb);
    return f;
  endfunction

  // Exponent all ones, mantissa zero, sign clear
  function automatic logic [FP_MAX_W-1:0] fp_inf_mag(input int exp_msb, input int exp_lsb);
    return fp_mask(exp_msb - exp_lsb + 1) << exp_lsb;
  endfunction

  // Sign 0, exponent all ones, only the mantissa MSB set
  function automatic logic [FP_MAX_W-1:0] fp_canon_qnan(input int exp_msb, input int exp_lsb);
    return fp_inf_mag(exp_msb, exp_lsb) | (64'd1 << (exp_lsb - 1));
  endfunction

  // Force the quiet bit (mantissa MSB); payload and sign are kept
  function automatic logic [FP_MAX_W-1:0] fp_quiet(input logic [FP_MAX_W-1:0] op,
                                                   input int exp_lsb);
    return op | (64'd1 << (exp_lsb - 1));
  endfunction

endpackage

// File: rtl/ieee_754_special_decoder.sv
// Combinational IEEE-754 special-value classifier for one operand.
module ieee_754_special_decoder
  import fp_special_pkg::*;
#(
  parameter int EXP_MSB_POS = 14,
  parameter int EXP_LSB_POS = 10,
  parameter int FP_WIDTH    = 16
) (
  input  logic [FP_WIDTH-1:0] op,
  output logic                sign,
  output logic                is_zero,
  output logic                is_inf,
  output logic                is_nan,
  output logic                is_snan
);

  localparam int EXP_W = EXP_MSB_POS - EXP_LSB_POS + 1;

  fp_fields_t f;
  logic       exp_ones;
  logic       mant_zero;

  // Field split and class flags; subnormals report no flag at all
  always_comb begin
    f         = fp_unpack(64'(op), FP_WIDTH, EXP_MSB_POS, EXP_LSB_POS);
    exp_ones  = (f.exp == fp_mask(EXP_W));
    mant_zero = (f.mant == '0);
    sign      = f.sign;
    is_zero   = (f.exp == '0) && mant_zero;
    is_inf    = exp_ones && mant_zero;
    is_nan    = exp_ones && !mant_zero;
    is_snan   = is_nan && !f.mant[EXP_LSB_POS-1];
  end

endmodule

// File: rtl/fp_mul_special_handler.sv
// Two-stage valid/ready front end for the FP multiplier: S1 captures the
// operand pair, S2 holds the special-case verdict alongside the operands.
module fp_mul_special_handler
  import fp_special_pkg::*;
#(
  parameter int EXP_MSB_POS = 14,
  parameter int EXP_LSB_POS = 10,
  parameter int FP_WIDTH    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [FP_WIDTH-1:0] op_a_i,
  input  logic [FP_WIDTH-1:0] op_b_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                special_o,
  output logic [FP_WIDTH-1:0] result_o,
  output logic [FP_WIDTH-1:0] op_a_o,
  output logic [FP_WIDTH-1:0] op_b_o,
  output logic                invalid_o,
  input  logic                sticky_clr_i,
  output logic                invalid_sticky_o
);

  localparam logic [FP_WIDTH-1:0] QNAN    = FP_WIDTH'(fp_canon_qnan(EXP_MSB_POS, EXP_LSB_POS));
  localparam logic [FP_WIDTH-1:0] INF_MAG = FP_WIDTH'(fp_inf_mag(EXP_MSB_POS, EXP_LSB_POS));

  // S1 / S2 state
  logic                s1_valid, s2_valid;
  logic [FP_WIDTH-1:0] s1_a, s1_b;
  logic                s2_special, s2_invalid;
  logic [FP_WIDTH-1:0] s2_result, s2_a, s2_b;
  logic                sticky;

  logic s2_adv;
  logic s1_adv;
  logic in_xfer;

  // Per-operand classification on the S1 registers
  logic sa, a_zero, a_inf, a_nan, a_snan;
  logic sb, b_zero, b_inf, b_nan, b_snan;

  ieee_754_special_decoder #(
    .EXP_MSB_POS(EXP_MSB_POS), .EXP_LSB_POS(EXP_LSB_POS), .FP_WIDTH(FP_WIDTH)
  ) u_dec_a (
    .op(s1_a), .sign(sa), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .is_snan(a_snan)
  );

  ieee_754_special_decoder #(
    .EXP_MSB_POS(EXP_MSB_POS), .EXP_LSB_POS(EXP_LSB_POS), .FP_WIDTH(FP_WIDTH)
  ) u_dec_b (
    .op(s1_b), .sign(sb), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .is_snan(b_snan)
  );

  fp_case_e            fcase;
  logic                nx_special;
  logic                nx_invalid;
  logic [FP_WIDTH-1:0] nx_result;
  logic [FP_WIDTH-1:0] signed_zero;

  // Handshake control; in_ready may see out_ready combinationally
  always_comb begin
    s2_adv     = ~s2_valid | out_ready_i;
    s1_adv     = s1_valid & s2_adv;
    in_ready_o = ~s1_valid | s2_adv;
    in_xfer    = in_valid_i & in_ready_o;
  end

  // Case priority and special-result selection
  always_comb begin
    signed_zero = {sa ^ sb, {(FP_WIDTH-1){1'b0}}};
    if (a_nan)                                fcase = CASE_NAN_A;
    else if (b_nan)                           fcase = CASE_NAN_B;
    else if ((a_inf & b_zero) | (a_zero & b_inf)) fcase = CASE_INF_ZERO;
    else if (a_inf | b_inf)                   fcase = CASE_INF;
    else if (a_zero | b_zero)                 fcase = CASE_ZERO;
    else                                      fcase = CASE_NORMAL;

    nx_special = 1'b1;
    unique case (fcase)
      CASE_NAN_A:    nx_result = FP_WIDTH'(fp_quiet(64'(s1_a), EXP_LSB_POS));
      CASE_NAN_B:    nx_result = FP_WIDTH'(fp_quiet(64'(s1_b), EXP_LSB_POS));
      CASE_INF_ZERO: nx_result = QNAN;
      CASE_INF:      nx_result = signed_zero | INF_MAG;
      CASE_ZERO:     nx_result = signed_zero;
      default: begin
        nx_result  = '0;
        nx_special = 1'b0;
      end
    endcase
    // an sNaN anywhere raises invalid even when a qNaN wins the result
    nx_invalid = a_snan | b_snan | (fcase == CASE_INF_ZERO);
  end

  // S1: operand capture on input transfer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      if (in_ready_o) s1_valid <= in_valid_i;
      if (in_xfer) begin
        s1_a <= op_a_i;
        s1_b <= op_b_i;
      end
    end
  end

  // S2: verdict + operands; frozen while the output is stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid   <= 1'b0;
      s2_special <= 1'b0;
      s2_invalid <= 1'b0;
      s2_result  <= '0;
      s2_a       <= '0;
      s2_b       <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_adv) begin
        s2_special <= nx_special;
        s2_invalid <= nx_invalid;
        s2_result  <= nx_result;
        s2_a       <= s1_a;
        s2_b       <= s1_b;
      end
    end
  end

  // Sticky invalid: a set on an output handshake beats a clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                    sticky <= 1'b0;
    else if (s2_valid & out_ready_i & s2_invalid)   sticky <= 1'b1;
    else if (sticky_clr_i)                          sticky <= 1'b0;
  end

  assign out_valid_o      = s2_valid;
  assign special_o        = s2_special;
  assign result_o         = s2_result;
  assign invalid_o        = s2_invalid;
  assign op_a_o           = s2_a;
  assign op_b_o           = s2_b;
  assign invalid_sticky_o = sticky;

endmodule

// File: tb/tb_fp_mul_special_handler.sv
// Self-checking bench: directed fp16 special cases, stall/stream, sticky and
// mid-flight reset, then randomized traffic against a scoreboard model.
module tb_fp_mul_special_handler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [15:0] op_a_i, op_b_i, result_o, op_a_o, op_b_o;
  logic        special_o, invalid_o, sticky_clr_i, invalid_sticky_o;

  fp_mul_special_handler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .special_o(special_o), .result_o(result_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .invalid_o(invalid_o), .sticky_clr_i(sticky_clr_i), .invalid_sticky_o(invalid_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [15:0] a, b; } pair_t;
  pair_t sb[$];

  int tests = 0, fails = 0, nout = 0;
  logic        sticky_exp = 1'b0;
  logic        seen_valid, last_in_xfer;
  logic        hold_pending = 1'b0;
  logic [35:0] hold_data;
  logic        obs_special, obs_invalid;
  logic [15:0] obs_result, obs_a, obs_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: {special, invalid, result} straight from the fp16 rules
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
    bit an = (a[14:10] == 5'h1f) && (a[9:0] != 0);
    bit bn = (b[14:10] == 5'h1f) && (b[9:0] != 0);
    bit as = an && !a[9];
    bit bs = bn && !b[9];
    bit ai = (a[14:0] == 15'h7c00);
    bit bi = (b[14:0] == 15'h7c00);
    bit az = (a[14:0] == 0);
    bit bz = (b[14:0] == 0);
    logic s = a[15] ^ b[15];
    if (an) return {1'b1, 1'(as | bs), a | 16'h0200};
    if (bn) return {1'b1, 1'(as | bs), b | 16'h0200};
    if ((ai && bz) || (az && bi)) return {2'b11, 16'h7e00};
    if (ai || bi) return {2'b10, s, 15'h7c00};
    if (az || bz) return {2'b10, s, 15'h0000};
    return 18'h0;
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] lst [12] = '{16'h0000, 16'h8000, 16'h7c00, 16'hfc00, 16'h7e00, 16'h7d00,
                              16'hfe01, 16'h7c01, 16'h3c00, 16'h0001, 16'h0400, 16'hc000};
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return lst[$urandom_range(0, 11)] ^ {1'($urandom_range(0, 1)), 15'h0};
  endfunction

  // One clock: sample mid-cycle, update scoreboard, cross the edge, check sticky
  task automatic tick();
    logic [17:0] e;
    #4;
    seen_valid   = out_valid_o;
    last_in_xfer = in_valid_i & in_ready_o;
    if (hold_pending) begin
      chk("hold_valid", 32'(out_valid_o), 1);
      chk("hold_data", {result_o, op_a_o[3:0], special_o, invalid_o, 14'(op_b_o)},
          32'(hold_data));
    end
    if (out_valid_o) begin
      obs_special = special_o; obs_invalid = invalid_o;
      obs_result  = result_o;  obs_a = op_a_o; obs_b = op_b_o;
      if (sb.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = model(sb[0].a, sb[0].b);
        chk("sb_special", 32'(special_o), 32'(e[17]));
        chk("sb_invalid", 32'(invalid_o), 32'(e[16]));
        chk("sb_result", 32'(result_o), 32'(e[15:0]));
        chk("sb_op_a", 32'(op_a_o), 32'(sb[0].a));
        chk("sb_op_b", 32'(op_b_o), 32'(sb[0].b));
      end
    end
    hold_pending = out_valid_o && !out_ready_i;
    hold_data    = 36'({result_o, op_a_o[3:0], special_o, invalid_o, 14'(op_b_o)});
    if (out_valid_o && out_ready_i && sb.size() > 0) begin
      e = model(sb[0].a, sb[0].b);
      void'(sb.pop_front());
      nout++;
      if (e[16]) sticky_exp = 1'b1;
      else if (sticky_clr_i) sticky_exp = 1'b0;
    end else if (sticky_clr_i) sticky_exp = 1'b0;
    if (last_in_xfer) sb.push_back({op_a_i, op_b_i});
    @(posedge clk_i); #1;
    chk("sticky", 32'(invalid_sticky_o), 32'(sticky_exp));
  endtask

  // Single transaction with free-flowing output; measures latency
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int lat;
    in_valid_i = 1'b1; op_a_i = a; op_b_i = b;
    tick();
    chk("send_xfer", 32'(last_in_xfer), 1);
    in_valid_i = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!seen_valid && lat < 8);
    chk("latency", lat, 2);
  endtask

  logic [15:0] dir_a   [6] = '{16'h7c00, 16'h7d00, 16'h7e01, 16'hfc00, 16'h8000, 16'h3c00};
  logic [15:0] dir_b   [6] = '{16'h0000, 16'h3c00, 16'hfd00, 16'h4000, 16'h3c00, 16'h0001};
  logic [15:0] dir_res [6] = '{16'h7e00, 16'h7f00, 16'h7e01, 16'hfc00, 16'h8000, 16'h0000};
  logic        dir_sp  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        dir_inv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int idx, cyc, n0;
    pair_t strm [5];
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; sticky_clr_i = 1'b0;
    op_a_i = '0; op_b_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 0);
    chk("rst_data", {result_o, op_a_o}, 0);
    chk("rst_flags", {special_o, invalid_o, invalid_sticky_o, op_b_o}, 0);
    rst_ni = 1'b1;
    chk("rst_in_ready", 32'(in_ready_o), 1);

    // Directed special cases
    out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(dir_a[i], dir_b[i]);
      chk("dir_result", 32'(obs_result), 32'(dir_res[i]));
      chk("dir_special", 32'(obs_special), 32'(dir_sp[i]));
      chk("dir_invalid", 32'(obs_invalid), 32'(dir_inv[i]));
      if (i == 0) chk("dir_sticky", 32'(invalid_sticky_o), 1);
    end
    chk("dir_op_a", 32'(obs_a), 32'h3c00);
    chk("dir_op_b", 32'(obs_b), 32'h0001);

    // Stream of 5 into a stalled output
    for (int i = 0; i < 5; i++) strm[i] = {pick(), pick()};
    out_ready_i = 1'b0; idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid_i = 1'b1; op_a_i = strm[idx].a; op_b_i = strm[idx].b;
      tick();
      if (last_in_xfer) idx++;
    end
    chk("stall_xfers", idx, 2);
    chk("stall_ready", 32'(in_ready_o), 0);
    out_ready_i = 1'b1; cyc = 0; n0 = nout;
    while (nout - n0 < 5 && cyc < 20) begin
      in_valid_i = (idx < 5);
      if (idx < 5) begin op_a_i = strm[idx].a; op_b_i = strm[idx].b; end
      tick();
      if (last_in_xfer) idx++;
      cyc++;
    end
    in_valid_i = 1'b0;
    chk("drain_count", nout - n0, 5);
    chk("drain_cycles", cyc, 5);

    // Sticky: set on the same cycle as clear wins, then clear alone
    sticky_clr_i = 1'b1; tick();
    chk("sticky_cleared", 32'(invalid_sticky_o), 0);
    send(16'h7c00, 16'h0000);
    chk("sticky_set_wins", 32'(invalid_sticky_o), 1);
    tick();
    chk("sticky_clr_next", 32'(invalid_sticky_o), 0);
    sticky_clr_i = 1'b0;

    // Reset with two transactions in flight
    send(16'h7d00, 16'h3c00);
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    op_a_i = 16'h7c00; op_b_i = 16'h0000; tick();
    op_a_i = 16'h4000; op_b_i = 16'h4000; tick();
    in_valid_i = 1'b0;
    chk("inflight_cnt", sb.size(), 2);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid_o), 0);
    chk("arst_sticky", 32'(invalid_sticky_o), 0);
    sb.delete(); sticky_exp = 1'b0; hold_pending = 1'b0;
    @(posedge clk_i); #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_ready", 32'(in_ready_o), 1);
    out_ready_i = 1'b1; n0 = nout;
    repeat (6) tick();
    chk("no_stale", nout - n0, 0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid_i   = ($urandom_range(0, 9) < 7);
      out_ready_i  = ($urandom_range(0, 9) < 7);
      sticky_clr_i = ($urandom_range(0, 9) == 0);
      op_a_i = pick(); op_b_i = pick();
      tick();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1; sticky_clr_i = 1'b0;
    repeat (4) tick();
    chk("final_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
